// File: rtl/wybor_jasnosci.sv
// -----------------------------------------------------------------------------
// wybor_jasnosci -- two-button brightness level selector.
//
// Two raw push buttons (up / down) are synchronised, debounced and turned into
// press events that step a 2-bit brightness level with saturation at 0 and 3.
// Holding exactly one button auto-repeats its step every REPEAT_CYCLES cycles.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed to accept a button change
//   REPEAT_CYCLES   : hold cycles between auto-repeat steps
//
// Ports
//   in_clk        : clock, rising edge
//   in_rst_n      : asynchronous active-low reset
//   in_btn_up     : raw button, active-high, bouncing, asynchronous
//   in_btn_down   : raw button, active-high, bouncing, asynchronous
//   out_przycisk1 : level MSB (PWM mux select)
//   out_przycisk2 : level LSB (PWM mux select)
//   out_zmiana    : one-cycle pulse when the level takes a new value
// -----------------------------------------------------------------------------
module wybor_jasnosci #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic in_btn_up,
    input  logic in_btn_down,
    output logic out_przycisk1,
    output logic out_przycisk2,
    output logic out_zmiana
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

    // Bit index of each button inside the 2-bit vectors below.
    localparam int UP = 0;
    localparam int DN = 1;

    logic [1:0]      raw;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      stan_q;
    logic [1:0]      stan_d;
    logic [1:0]      stan_prev_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [RP_W-1:0] rep_q;
    logic [RP_W-1:0] rep_d;
    logic [1:0]      poziom_q;
    logic [1:0]      poziom_d;
    logic            zmiana_q;
    logic            zmiana_d;

    logic [1:0]      press;
    logic            press_any;
    logic            only_up;
    logic            only_dn;
    logic            rep_hit;
    logic            step_up;
    logic            step_dn;

    assign raw = {in_btn_down, in_btn_up};

    // Press = rising edge of the debounced state, seen one cycle after the
    // toggle; releases are deliberately ignored.
    assign press     = stan_q & ~stan_prev_q;
    assign press_any = |press;
    assign only_up   = stan_q[UP] & ~stan_q[DN];
    assign only_dn   = stan_q[DN] & ~stan_q[UP];

    // Debounce: count consecutive cycles of disagreement between the
    // synchronised input and the accepted state; any agreement restarts.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stan_d[i]   = stan_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stan_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stan_d[i] = ~stan_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Auto-repeat and level update.
    always_comb begin
        rep_d    = '0;
        rep_hit  = 1'b0;
        poziom_d = poziom_q;
        step_up  = 1'b0;
        step_dn  = 1'b0;

        // A fresh press restarts the repeat interval; holding both buttons
        // or releasing keeps it cleared.
        if ((only_up || only_dn) && !press_any) begin
            if (rep_q == RP_LAST) begin
                rep_hit = 1'b1;
            end else begin
                rep_d = rep_q + RP_W'(1);
            end
        end

        // A press only counts while the other button is not held; this also
        // rejects simultaneous presses, since both states are then 1.
        step_up = (press[UP] & ~stan_q[DN]) | (rep_hit & only_up);
        step_dn = (press[DN] & ~stan_q[UP]) | (rep_hit & only_dn);

        if (step_up && (poziom_q != 2'd3)) begin
            poziom_d = poziom_q + 2'd1;
        end else if (step_dn && (poziom_q != 2'd0)) begin
            poziom_d = poziom_q - 2'd1;
        end

        zmiana_d = (poziom_d != poziom_q);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stan_q      <= '0;
            stan_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
            rep_q       <= '0;
            poziom_q    <= '0;
            zmiana_q    <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            stan_q      <= stan_d;
            stan_prev_q <= stan_q;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            rep_q       <= rep_d;
            poziom_q    <= poziom_d;
            zmiana_q    <= zmiana_d;
        end
    end

    assign out_przycisk1 = poziom_q[1];
    assign out_przycisk2 = poziom_q[0];
    assign out_zmiana    = zmiana_q;

endmodule
